// File: rtl/serial_demux_transmitter.sv
// serial_demux_transmitter
// Receives framed bit-serial packets (start, address, length, payload,
// optional even-parity bit) on one line and forwards the payload bits,
// one cycle later, to the addressed serial output port.
module serial_demux_transmitter #(
  parameter int ADDR_W    = 2,
  parameter int LEN_W     = 4,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   serin,
  output logic [2**ADDR_W-1:0]   serout,
  output logic [2**ADDR_W-1:0]   out_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   parity_err,
  output logic [ADDR_W-1:0]      cur_port
);

  localparam int NUM_PORTS = 2**ADDR_W;
  // One counter and one shift register serve both header fields.
  localparam int CNT_W     = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    LEN    = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  // Holds the already-received header bits; the incoming bit completes the field.
  logic [CNT_W-2:0]       shift_reg, shift_next;
  logic [CNT_W-1:0]       shift_in;
  logic [LEN_W-1:0]       len_cnt_reg, len_cnt_next;
  logic                   par_reg, par_next;
  logic [ADDR_W-1:0]      cur_port_reg, cur_port_next;
  logic [NUM_PORTS-1:0]   serout_reg, serout_next;
  logic [NUM_PORTS-1:0]   out_valid_reg, out_valid_next;
  logic                   done_reg, done_next;
  logic                   perr_reg, perr_next;

  assign shift_in = {shift_reg, serin};

  // Next-state and next-output logic; outputs default to idle values each cycle.
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_in[CNT_W-2:0];
    len_cnt_next   = len_cnt_reg;
    par_next       = par_reg;
    cur_port_next  = cur_port_reg;
    serout_next    = {NUM_PORTS{1'b1}};
    out_valid_next = '0;
    done_next      = 1'b0;
    perr_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        shift_next = '0;
        if (!serin) begin
          state_next   = ADDR;
          bit_cnt_next = '0;
          par_next     = 1'b0;
        end
      end

      ADDR: begin
        if (bit_cnt_reg == CNT_W'(ADDR_W - 1)) begin
          cur_port_next = shift_in[ADDR_W-1:0];
          state_next    = LEN;
          bit_cnt_next  = '0;
          shift_next    = '0;
        end else begin
          bit_cnt_next = bit_cnt_reg + CNT_W'(1);
        end
      end

      LEN: begin
        if (bit_cnt_reg == CNT_W'(LEN_W - 1)) begin
          len_cnt_next = shift_in[LEN_W-1:0];
          bit_cnt_next = '0;
          shift_next   = '0;
          if (shift_in[LEN_W-1:0] != '0) begin
            state_next = DATA;
          end else if (PARITY_EN) begin
            state_next = PARITY;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + CNT_W'(1);
        end
      end

      DATA: begin
        serout_next[cur_port_reg]    = serin;
        out_valid_next[cur_port_reg] = 1'b1;
        par_next                     = par_reg ^ serin;
        len_cnt_next                 = len_cnt_reg - LEN_W'(1);
        if (len_cnt_reg == LEN_W'(1)) begin
          if (PARITY_EN) begin
            state_next = PARITY;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end

      PARITY: begin
        // Even parity: payload bits XOR parity bit must be zero.
        perr_next  = par_reg ^ serin;
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; asynchronous active-low reset abandons any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      len_cnt_reg   <= '0;
      par_reg       <= 1'b0;
      cur_port_reg  <= '0;
      serout_reg    <= {NUM_PORTS{1'b1}};
      out_valid_reg <= '0;
      done_reg      <= 1'b0;
      perr_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      len_cnt_reg   <= len_cnt_next;
      par_reg       <= par_next;
      cur_port_reg  <= cur_port_next;
      serout_reg    <= serout_next;
      out_valid_reg <= out_valid_next;
      done_reg      <= done_next;
      perr_reg      <= perr_next;
    end
  end

  // busy drops in the same cycle done rises because the FSM is back in IDLE.
  assign busy       = (state_reg != IDLE);
  assign serout     = serout_reg;
  assign out_valid  = out_valid_reg;
  assign done       = done_reg;
  assign parity_err = perr_reg;
  assign cur_port   = cur_port_reg;

endmodule

// File: tb/tb_serial_demux_transmitter.sv
// Testbench for serial_demux_transmitter: directed frame table, hand-written
// back-to-back and mid-frame-reset sequences, and random frame streams
// checked cycle by cycle against a frame-level reference model.
module tb_serial_demux_transmitter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic serin0 = 1'b1;
  logic serin1 = 1'b1;

  logic [3:0] serout_a, valid_a, serout_b, valid_b;
  logic       busy_a, done_a, perr_a, busy_b, done_b, perr_b;
  logic [1:0] port_a, port_b;

  int total = 0;
  int bad   = 0;

  // Selects which instance the directed tasks drive and observe.
  logic       sel = 1'b0;
  logic [3:0] m_serout, m_valid;
  logic       m_busy, m_done, m_perr;
  logic [1:0] m_port;

  always #5 clk = ~clk;

  serial_demux_transmitter #(.ADDR_W(2), .LEN_W(4), .PARITY_EN(1'b0)) dut_a (
    .clk(clk), .rst(rst), .serin(serin0), .serout(serout_a), .out_valid(valid_a),
    .busy(busy_a), .done(done_a), .parity_err(perr_a), .cur_port(port_a)
  );

  serial_demux_transmitter #(.ADDR_W(2), .LEN_W(4), .PARITY_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .serin(serin1), .serout(serout_b), .out_valid(valid_b),
    .busy(busy_b), .done(done_b), .parity_err(perr_b), .cur_port(port_b)
  );

  always_comb begin
    if (sel) begin
      m_serout = serout_b; m_valid = valid_b; m_busy = busy_b;
      m_done = done_b; m_perr = perr_b; m_port = port_b;
    end else begin
      m_serout = serout_a; m_valid = valid_a; m_busy = busy_a;
      m_done = done_a; m_perr = perr_a; m_port = port_a;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 60) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic drive(input logic b);
    if (sel) begin serin1 = b; serin0 = 1'b1; end
    else     begin serin0 = b; serin1 = 1'b1; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed frame table ----------------
  typedef struct {
    logic        par;
    logic [1:0]  addr;
    logic [3:0]  len;
    logic [15:0] payload;
    logic        pbit;
    logic [3:0]  exp_valid;
    logic [1:0]  exp_port;
    logic        exp_perr;
    int          exp_nbits;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    logic        bits[64];
    int          n = 0;
    logic [15:0] got = '0;
    int          nv = 0;
    int          ndone = 0;
    int          done_at = -1;
    sel = v.par;
    bits[n] = 1'b0; n++;
    for (int k = 0; k < 2; k++) begin bits[n] = v.addr[1-k]; n++; end
    for (int k = 0; k < 4; k++) begin bits[n] = v.len[3-k]; n++; end
    for (int k = 0; k < int'(v.len); k++) begin bits[n] = v.payload[int'(v.len)-1-k]; n++; end
    if (v.par) begin bits[n] = v.pbit; n++; end
    for (int i = 0; i < n + 4; i++) begin
      drive(i < n ? bits[i] : 1'b1);
      tick();
      if (m_valid != 4'b0) begin
        chk("vec_valid", 32'(m_valid), 32'(v.exp_valid));
        got = {got[14:0], m_serout[v.exp_port]};
        nv++;
      end
      if (m_done) begin
        ndone++;
        done_at = i;
        chk("vec_perr", 32'(m_perr), 32'(v.exp_perr));
        chk("vec_port", 32'(m_port), 32'(v.exp_port));
      end
    end
    $display("vec addr=%0d len=%0d par=%0d: nvalid=%0d done_at=%0d payload=%0h", v.addr, v.len, v.par, nv, done_at + 1, got);
    chk("vec_ndone", 32'(ndone), 32'd1);
    chk("vec_done_at", 32'(done_at + 1), 32'(v.exp_nbits));
    chk("vec_nvalid", 32'(nv), 32'(v.len));
    chk("vec_payload", 32'(got), 32'(v.payload));
  endtask

  // ---------------- random streams vs. frame-level model ----------------
  localparam int RN = 2000;
  logic       r_bits[RN];
  logic [3:0] r_valid[RN];
  logic [3:0] r_ser[RN];
  logic       r_done[RN];
  logic       r_perr[RN];
  logic       r_busy[RN];
  logic       r_set[RN];
  logic [1:0] r_newp[RN];
  logic [1:0] r_port[RN];

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_random(input logic par, input int nframes);
    int         pos = 0;
    int         s, e, idx;
    logic [1:0] a;
    logic [3:0] l;
    logic       b, x, pb;
    logic [1:0] cur;
    int         nf = 0;
    sel = par;
    for (int i = 0; i < RN; i++) begin
      r_bits[i] = 1'b1; r_valid[i] = '0; r_ser[i] = 4'hF; r_done[i] = 1'b0;
      r_perr[i] = 1'b0; r_busy[i] = 1'b0; r_set[i] = 1'b0; r_newp[i] = '0;
    end
    for (int f = 0; f < nframes && pos < RN - 40; f++) begin
      pos += $urandom_range(0, 3);
      a = 2'($urandom_range(0, 3));
      l = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      s = pos;
      r_bits[s] = 1'b0;
      for (int k = 0; k < 2; k++) r_bits[s+1+k] = a[1-k];
      r_set[s+2] = 1'b1; r_newp[s+2] = a;
      for (int k = 0; k < 4; k++) r_bits[s+3+k] = l[3-k];
      x = 1'b0;
      for (int j = 0; j < int'(l); j++) begin
        b = 1'($urandom_range(0, 1));
        idx = s + 7 + j;
        r_bits[idx] = b;
        x ^= b;
        r_valid[idx] = 4'(1) << a;
        r_ser[idx][a] = b;
      end
      e = s + 6 + int'(l);
      if (par) begin
        e++;
        pb = 1'($urandom_range(0, 1));
        r_bits[e] = pb;
        r_perr[e] = x ^ pb;
      end
      r_done[e] = 1'b1;
      for (int t = s; t < e; t++) r_busy[t] = 1'b1;
      pos = e + 1;
      nf++;
    end
    cur = 2'd0;
    for (int i = 0; i < RN; i++) begin
      if (r_set[i]) cur = r_newp[i];
      r_port[i] = cur;
    end
    $display("random par=%0d: %0d frames over %0d cycles", par, nf, pos);
    for (int i = 0; i < pos + 3; i++) begin
      drive(r_bits[i]);
      tick();
      chk("rnd_valid",  32'(m_valid),  32'(r_valid[i]));
      chk("rnd_serout", 32'(m_serout), 32'(r_ser[i]));
      chk("rnd_busy",   32'(m_busy),   32'(r_busy[i]));
      chk("rnd_done",   32'(m_done),   32'(r_done[i]));
      chk("rnd_perr",   32'(m_perr),   32'(r_perr[i]));
      chk("rnd_port",   32'(m_port),   32'(r_port[i]));
    end
  endtask

  initial begin
    logic [18:0] bb;
    int          c2, c0, nd, first_done, last_done;
    logic [7:0]  pre;

    vecs[0] = '{1'b0, 2'd1, 4'd5,  16'b10111,  1'b0, 4'b0010, 2'd1, 1'b0, 12};
    vecs[1] = '{1'b0, 2'd3, 4'd0,  16'h0000,   1'b0, 4'b0000, 2'd3, 1'b0, 7};
    vecs[2] = '{1'b1, 2'd2, 4'd4,  16'b1101,   1'b1, 4'b0100, 2'd2, 1'b0, 12};
    vecs[3] = '{1'b1, 2'd2, 4'd4,  16'b1101,   1'b0, 4'b0100, 2'd2, 1'b1, 12};
    vecs[4] = '{1'b1, 2'd0, 4'd0,  16'h0000,   1'b1, 4'b0000, 2'd0, 1'b1, 8};
    vecs[5] = '{1'b0, 2'd0, 4'd15, 16'h5A3C,   1'b0, 4'b0001, 2'd0, 1'b0, 22};

    // Reset held for two cycles.
    rst = 1'b0;
    tick();
    tick();
    $display("reset: serout=%b valid=%b busy=%b done=%b port=%0d", serout_a, valid_a, busy_a, done_a, port_a);
    chk("rst_serout", 32'(serout_a), 32'hF);
    chk("rst_valid",  32'(valid_a),  32'h0);
    chk("rst_busy",   32'(busy_a),   32'h0);
    chk("rst_done",   32'(done_a),   32'h0);
    chk("rst_perr",   32'(perr_a),   32'h0);
    chk("rst_port",   32'(port_a),   32'h0);
    chk("rst_serout_b", 32'(serout_b), 32'hF);
    @(negedge clk);
    rst = 1'b1;

    // Idle line for ten cycles.
    for (int i = 0; i < 10; i++) begin
      serin0 = 1'b1; serin1 = 1'b1;
      tick();
      $display("idle %0d: serout=%b valid=%b busy=%b done=%b", i, serout_a, valid_a, busy_a, done_a);
      chk("idle_serout", 32'(serout_a), 32'hF);
      chk("idle_valid",  32'(valid_a | valid_b), 32'h0);
      chk("idle_busy",   32'(busy_a | busy_b), 32'h0);
      chk("idle_done",   32'(done_a | done_b), 32'h0);
    end

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Back-to-back: port 2 len 3 payload 101, then port 0 len 2 payload 01, no gap.
    sel = 1'b0;
    bb = 19'b0_10_0011_101_0_00_0010_01;
    c2 = 0; c0 = 0; nd = 0; first_done = -1; last_done = -1;
    for (int i = 0; i < 23; i++) begin
      drive(i < 19 ? bb[18-i] : 1'b1);
      tick();
      if (valid_a == 4'b0100) c2++;
      if (valid_a == 4'b0001) c0++;
      if (valid_a != 4'b0000 && valid_a != 4'b0100 && valid_a != 4'b0001)
        chk("b2b_valid_onehot", 32'(valid_a), 32'h0);
      if (done_a) begin
        nd++;
        if (first_done < 0) first_done = i;
        last_done = i;
      end
    end
    $display("b2b: port2 cycles=%0d port0 cycles=%0d dones=%0d at %0d,%0d", c2, c0, nd, first_done, last_done);
    chk("b2b_port2_cycles", 32'(c2), 32'd3);
    chk("b2b_port0_cycles", 32'(c0), 32'd2);
    chk("b2b_ndone", 32'(nd), 32'd2);
    chk("b2b_first_done", 32'(first_done), 32'd9);
    chk("b2b_last_done", 32'(last_done), 32'd18);
    chk("b2b_port", 32'(port_a), 32'd0);

    // Reset during the third data bit of a length-8 frame to port 2.
    sel = 1'b0;
    pre = 8'b0_10_1000_1;
    for (int i = 0; i < 8; i++) begin drive(pre[7-i]); tick(); end
    drive(1'b0);
    tick();
    chk("mid_pre_valid", 32'(valid_a), 32'b0100);
    drive(1'b1);
    #2 rst = 1'b0;
    #1;
    $display("mid-reset: serout=%b valid=%b busy=%b done=%b port=%0d", serout_a, valid_a, busy_a, done_a, port_a);
    chk("mid_serout", 32'(serout_a), 32'hF);
    chk("mid_valid",  32'(valid_a),  32'h0);
    chk("mid_busy",   32'(busy_a),   32'h0);
    chk("mid_port",   32'(port_a),   32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1);
      tick();
      if (done_a || valid_a != 4'b0) nd++;
    end
    chk("mid_no_done", 32'(nd), 32'd0);
    run_vec(vecs[0]);

    pulse_reset();
    run_random(1'b0, 40);
    pulse_reset();
    run_random(1'b1, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
